// File: rtl/elevator_pkg.sv
// Shared types and constants for the three-floor elevator controller.
package elevator_pkg;

   localparam int FLOOR_W    = 2;
   localparam int MAX_FLOOR  = 2;
   localparam int NUM_FLOORS = 3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MOVE_UP   = 3'd1,
      MOVE_DOWN = 3'd2,
      DOOR_OPEN = 3'd3,
      HALT      = 3'd4
   } state_t;

   // Mask of floors strictly above f.
   function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i > int'(f)) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i < int'(f)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/elevator_floor_ctrl_if.sv
// Signal bundle between the floor controller and its surroundings (buttons,
// move-timing block, display/door logic). State is exported for observation.
interface elevator_floor_ctrl_if;
   import elevator_pkg::*;

   // No valid/ready handshake: buttons are async active-low levels, move_clk is
   // a level whose rising edge is one step, and all outputs are plain status.
   logic                  button1;
   logic                  button2;
   logic                  button3;
   logic                  move_clk;
   logic                  sos_mode;
   logic                  weight_limit_exceeded;
   logic [FLOOR_W-1:0]    current_floor;
   logic                  moving;
   logic                  dir_up;
   logic                  door_open;
   logic [NUM_FLOORS-1:0] requests;
   logic                  arrived;
   state_t                state;

   modport master (
      output button1, button2, button3, move_clk, sos_mode, weight_limit_exceeded,
      input  current_floor, moving, dir_up, door_open, requests, arrived, state
   );

   modport slave (
      input  button1, button2, button3, move_clk, sos_mode, weight_limit_exceeded,
      output current_floor, moving, dir_up, door_open, requests, arrived, state
   );

endinterface

// File: rtl/button_sync.sv
// Two-flop synchronizer for an active-low button plus a one-cycle press pulse
// on the synchronized falling edge.
module button_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);

   logic sync1;
   logic sync2;
   logic sync2_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         sync2_d <= 1'b1;
      end else begin
         sync1   <= btn_n;
         sync2   <= sync1;
         sync2_d <= sync2;
      end
   end

   assign press = sync2_d & ~sync2;

endmodule

// File: rtl/elevator_floor_ctrl.sv
// Floor controller: owns car position, latched calls, travel direction and
// door timing; advances one floor or one door tick per move_clk step.
module elevator_floor_ctrl
   import elevator_pkg::*;
#(
   parameter int DOOR_STEPS = 2
) (
   input logic            clk,
   input logic            rst_n,
   elevator_floor_ctrl_if.slave bus
);

   state_t                state, state_n;
   logic [FLOOR_W-1:0]    floor_q, floor_n, nf;
   logic                  dir_q, dir_n;
   logic [NUM_FLOORS-1:0] req_q, set, clr;
   logic [3:0]            cnt_q, cnt_n;
   logic                  arrived_q, arrived_n;
   logic                  move_clk_d;
   logic                  step;
   logic                  req_above, req_below;

   button_sync u_sync0 (.clk(clk), .rst_n(rst_n), .btn_n(bus.button1), .press(set[0]));
   button_sync u_sync1 (.clk(clk), .rst_n(rst_n), .btn_n(bus.button2), .press(set[1]));
   button_sync u_sync2 (.clk(clk), .rst_n(rst_n), .btn_n(bus.button3), .press(set[2]));

   assign step      = bus.move_clk & ~move_clk_d;
   assign req_above = |(req_q & above_mask(floor_q));
   assign req_below = |(req_q & below_mask(floor_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         floor_q    <= '0;
         dir_q      <= 1'b1;
         req_q      <= '0;
         cnt_q      <= '0;
         arrived_q  <= 1'b0;
         move_clk_d <= 1'b0;
      end else begin
         state      <= state_n;
         floor_q    <= floor_n;
         dir_q      <= dir_n;
         // A clear in the same cycle as a set wins: the car is at that floor.
         req_q      <= (req_q | set) & ~clr;
         cnt_q      <= cnt_n;
         arrived_q  <= arrived_n;
         move_clk_d <= bus.move_clk;
      end
   end

   always_comb begin
      state_n   = state;
      floor_n   = floor_q;
      dir_n     = dir_q;
      cnt_n     = cnt_q;
      clr       = '0;
      arrived_n = 1'b0;
      nf        = floor_q;

      if (bus.sos_mode) begin
         state_n = HALT;
      end else begin
         case (state)
            IDLE: begin
               if (req_q[floor_q]) begin
                  state_n      = DOOR_OPEN;
                  clr[floor_q] = 1'b1;
                  arrived_n    = 1'b1;
                  cnt_n        = 4'(DOOR_STEPS);
               end else if (!bus.weight_limit_exceeded) begin
                  if (req_above) begin
                     state_n = MOVE_UP;
                     dir_n   = 1'b1;
                  end else if (req_below) begin
                     state_n = MOVE_DOWN;
                     dir_n   = 1'b0;
                  end
               end
            end

            MOVE_UP, MOVE_DOWN: begin
               if (step) begin
                  if (state == MOVE_UP)
                     nf = (floor_q == FLOOR_W'(MAX_FLOOR)) ? floor_q : floor_q + 2'd1;
                  else
                     nf = (floor_q == '0) ? floor_q : floor_q - 2'd1;
                  floor_n = nf;
                  if (req_q[nf]) begin
                     state_n   = DOOR_OPEN;
                     clr[nf]   = 1'b1;
                     arrived_n = 1'b1;
                     cnt_n     = 4'(DOOR_STEPS);
                  end else if (nf == floor_q) begin
                     state_n = IDLE;
                  end
               end
            end

            DOOR_OPEN: begin
               if (set[floor_q] || req_q[floor_q]) begin
                  clr[floor_q] = 1'b1;
                  cnt_n        = 4'(DOOR_STEPS);
               end else if (!bus.weight_limit_exceeded && step) begin
                  if (cnt_q <= 4'd1) begin
                     cnt_n = '0;
                     // Keep going the same way while calls remain ahead.
                     if (dir_q && req_above) begin
                        state_n = MOVE_UP;
                     end else if (!dir_q && req_below) begin
                        state_n = MOVE_DOWN;
                     end else if (req_above) begin
                        state_n = MOVE_UP;
                        dir_n   = 1'b1;
                     end else if (req_below) begin
                        state_n = MOVE_DOWN;
                        dir_n   = 1'b0;
                     end else begin
                        state_n = IDLE;
                     end
                  end else begin
                     cnt_n = cnt_q - 4'd1;
                  end
               end
            end

            HALT:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.current_floor = floor_q;
   assign bus.moving        = (state == MOVE_UP) || (state == MOVE_DOWN);
   assign bus.dir_up        = dir_q;
   assign bus.door_open     = (state == DOOR_OPEN);
   assign bus.requests      = req_q;
   assign bus.arrived       = arrived_q;
   assign bus.state         = state;

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Directed bench for elevator_floor_ctrl: arrival floors are queued when calls
// are placed and checked whenever the controller pulses arrived.
module tb_elevator_floor_ctrl;
   import elevator_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] exp_q[$];

   elevator_floor_ctrl_if bus ();

   elevator_floor_ctrl #(.DOOR_STEPS(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic step(input int w);
      bus.move_clk = 1'b1;
      cyc(w);
      bus.move_clk = 1'b0;
      cyc(1);
   endtask

   task automatic rstep();
      step(int'($urandom_range(1, 3)));
   endtask

   task automatic set_btn(input int idx, input logic v);
      case (idx)
         0:       bus.button1 = v;
         1:       bus.button2 = v;
         default: bus.button3 = v;
      endcase
   endtask

   // From idle at floor 2: call floor 0 and ride down.
   task automatic ride_down();
      set_btn(0, 1'b0);
      exp_q.push_back(8'd0);
      cyc(4);
      chk("down_state", 8'(bus.state), 8'(MOVE_DOWN));
      chk("down_dir", 8'(bus.dir_up), 8'd0);
      set_btn(0, 1'b1);
      rstep();
      chk("down_floor1", 8'(bus.current_floor), 8'd1);
      rstep();
      chk("down_floor0", 8'(bus.current_floor), 8'd0);
      chk("down_door", 8'(bus.door_open), 8'd1);
      rstep();
      rstep();
      chk("down_idle", 8'(bus.state), 8'(IDLE));
   endtask

   // Scoreboard: every arrival pulse must match the oldest queued floor.
   always @(negedge clk) begin
      if (rst_n && bus.arrived === 1'b1) begin
         if (exp_q.size() > 0) chk("arrive_floor", 8'(bus.current_floor), exp_q.pop_front());
         else                  chk("arrive_unexpected", 8'(bus.current_floor), 8'hFF);
      end
   end

   initial begin
      bus.button1 = 1'b1;
      bus.button2 = 1'b1;
      bus.button3 = 1'b1;
      bus.move_clk = 1'b0;
      bus.sos_mode = 1'b0;
      bus.weight_limit_exceeded = 1'b0;
      cyc(2);
      chk("rst_floor", 8'(bus.current_floor), 8'd0);
      chk("rst_dir", 8'(bus.dir_up), 8'd1);
      chk("rst_req", 8'(bus.requests), 8'd0);
      chk("rst_state", 8'(bus.state), 8'(IDLE));
      rst_n = 1'b1;
      cyc(2);

      // Single call 0 -> 2 with exact request latency.
      set_btn(2, 1'b0);
      exp_q.push_back(8'd2);
      cyc(2);
      chk("lat_2clk", 8'(bus.requests), 8'd0);
      cyc(1);
      chk("lat_3clk", 8'(bus.requests), 8'b100);
      chk("lat_still_idle", 8'(bus.moving), 8'd0);
      cyc(1);
      chk("single_moving", 8'(bus.moving), 8'd1);
      chk("single_dir", 8'(bus.dir_up), 8'd1);
      set_btn(2, 1'b1);
      step(3);
      chk("single_floor1", 8'(bus.current_floor), 8'd1);
      rstep();
      chk("single_floor2", 8'(bus.current_floor), 8'd2);
      chk("single_door", 8'(bus.door_open), 8'd1);
      chk("single_req_clr", 8'(bus.requests), 8'd0);
      chk("single_arr_1cyc", 8'(bus.arrived), 8'd0);
      rstep();
      chk("single_door_hold", 8'(bus.door_open), 8'd1);
      rstep();
      chk("single_door_shut", 8'(bus.door_open), 8'd0);
      chk("single_idle", 8'(bus.state), 8'(IDLE));

      ride_down();

      // Pass-through stop at floor 1 on the way to 2.
      set_btn(1, 1'b0);
      set_btn(2, 1'b0);
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd2);
      cyc(4);
      chk("pass_up", 8'(bus.state), 8'(MOVE_UP));
      set_btn(1, 1'b1);
      set_btn(2, 1'b1);
      rstep();
      chk("pass_stop1", 8'(bus.door_open), 8'd1);
      chk("pass_req", 8'(bus.requests), 8'b100);
      rstep();
      chk("pass_door1", 8'(bus.door_open), 8'd1);
      rstep();
      chk("pass_resume", 8'(bus.state), 8'(MOVE_UP));
      chk("pass_dir", 8'(bus.dir_up), 8'd1);
      rstep();
      chk("pass_floor2", 8'(bus.current_floor), 8'd2);
      rstep();
      rstep();
      chk("pass_idle", 8'(bus.state), 8'(IDLE));

      ride_down();

      // SOS mid-trip at floor 1, then reversal after serving floor 2.
      set_btn(2, 1'b0);
      exp_q.push_back(8'd2);
      cyc(4);
      set_btn(2, 1'b1);
      rstep();
      chk("sos_at1", 8'(bus.current_floor), 8'd1);
      bus.sos_mode = 1'b1;
      step(1);
      chk("sos_state", 8'(bus.state), 8'(HALT));
      chk("sos_moving", 8'(bus.moving), 8'd0);
      chk("sos_same_cycle_step", 8'(bus.current_floor), 8'd1);
      rstep();
      chk("sos_step_ignored", 8'(bus.current_floor), 8'd1);
      set_btn(0, 1'b0);
      exp_q.push_back(8'd0);
      cyc(3);
      chk("sos_req_latch", 8'(bus.requests), 8'b101);
      set_btn(0, 1'b1);
      cyc(1);
      bus.sos_mode = 1'b0;
      cyc(1);
      chk("sos_release_idle", 8'(bus.state), 8'(IDLE));
      cyc(1);
      chk("sos_resume_up", 8'(bus.state), 8'(MOVE_UP));
      rstep();
      chk("rev_floor2", 8'(bus.current_floor), 8'd2);
      rstep();
      rstep();
      chk("rev_moving", 8'(bus.moving), 8'd1);
      chk("rev_dir", 8'(bus.dir_up), 8'd0);
      rstep();
      chk("rev_floor1", 8'(bus.current_floor), 8'd1);
      rstep();
      chk("rev_floor0", 8'(bus.current_floor), 8'd0);
      rstep();
      rstep();
      chk("rev_idle", 8'(bus.state), 8'(IDLE));

      // Overload freezes the door; a same-floor call reloads it.
      set_btn(2, 1'b0);
      exp_q.push_back(8'd2);
      cyc(4);
      set_btn(2, 1'b1);
      rstep();
      rstep();
      chk("ovl_door", 8'(bus.door_open), 8'd1);
      bus.weight_limit_exceeded = 1'b1;
      repeat (5) rstep();
      chk("ovl_frozen", 8'(bus.state), 8'(DOOR_OPEN));
      bus.weight_limit_exceeded = 1'b0;
      rstep();
      chk("ovl_tick1", 8'(bus.door_open), 8'd1);
      set_btn(2, 1'b0);
      cyc(3);
      chk("reload_req0", 8'(bus.requests), 8'd0);
      cyc(2);
      set_btn(2, 1'b1);
      rstep();
      chk("reload_open", 8'(bus.door_open), 8'd1);
      chk("reload_req_stay0", 8'(bus.requests), 8'd0);
      rstep();
      chk("reload_shut", 8'(bus.door_open), 8'd0);
      chk("reload_idle", 8'(bus.state), 8'(IDLE));
      chk("sb_drained", 8'(exp_q.size()), 8'd0);

      // Reset mid-move at floor 1.
      ride_down();
      set_btn(2, 1'b0);
      exp_q.push_back(8'd2);
      cyc(4);
      set_btn(2, 1'b1);
      rstep();
      chk("pre_rst_floor", 8'(bus.current_floor), 8'd1);
      chk("pre_rst_state", 8'(bus.state), 8'(MOVE_UP));
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_floor", 8'(bus.current_floor), 8'd0);
      chk("mid_rst_moving", 8'(bus.moving), 8'd0);
      chk("mid_rst_dir", 8'(bus.dir_up), 8'd1);
      chk("mid_rst_door", 8'(bus.door_open), 8'd0);
      chk("mid_rst_req", 8'(bus.requests), 8'd0);
      chk("mid_rst_arr", 8'(bus.arrived), 8'd0);
      chk("mid_rst_state", 8'(bus.state), 8'(IDLE));
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      chk("post_rst_idle", 8'(bus.state), 8'(IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
